// File: rtl/pes_graycode_updown.sv
// Parametrised up/down Gray counter: wrap/saturate, Gray parallel load, tc pulse.
// Optional prescaler compiled in with `define PES_GRAYCODE_PRESCALE_EN.
module pes_graycode_updown #(
    parameter int WIDTH    = 8,
    parameter int PRESCALE = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             dir,
    input  logic             mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] gray_count,
    output logic [WIDTH-1:0] bin_count,
    output logic             tc
);

    logic [WIDTH-1:0] bin_q;
    logic [WIDTH-1:0] gray_q;
    logic             tc_q;

    logic [WIDTH-1:0] load_bin;
    logic [WIDTH-1:0] step_bin;
    logic [WIDTH-1:0] next_bin;
    logic             at_term;
    logic             step;
    logic             next_tc;

    // Gray-to-binary: each bit is the XOR of all load bits at or above it
    always_comb begin
        load_bin = '0;
        load_bin[WIDTH-1] = load_value[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            load_bin[i] = load_bin[i+1] ^ load_value[i];
        end
    end

`ifdef PES_GRAYCODE_PRESCALE_EN
    localparam int PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] pre_q;

    assign step = enable && (pre_q == PRE_LAST);

    always_ff @(posedge clk) begin
        if (!reset) begin
            pre_q <= '0;
        end else if (load) begin
            pre_q <= '0;
        end else if (enable) begin
            pre_q <= step ? '0 : pre_q + PW'(1);
        end
    end
`else
    assign step = enable;
`endif

    assign at_term = dir ? (&bin_q) : ~(|bin_q);

    // Wrap falls out of modulo arithmetic; only saturate needs a hold
    always_comb begin
        step_bin = '0;
        if (at_term && mode) begin
            step_bin = bin_q;
        end else if (dir) begin
            step_bin = bin_q + WIDTH'(1);
        end else begin
            step_bin = bin_q - WIDTH'(1);
        end
    end

    always_comb begin
        next_bin = bin_q;
        next_tc  = 1'b0;
        if (load) begin
            next_bin = load_bin;
        end else if (step) begin
            next_bin = step_bin;
            next_tc  = at_term;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            bin_q  <= '0;
            gray_q <= '0;
            tc_q   <= 1'b0;
        end else begin
            bin_q  <= next_bin;
            gray_q <= next_bin ^ (next_bin >> 1);
            tc_q   <= next_tc;
        end
    end

    assign gray_count = gray_q;
    assign bin_count  = bin_q;
    assign tc         = tc_q;

endmodule

// File: tb/tb_pes_graycode_updown.sv
// Directed bench for pes_graycode_updown at WIDTH=8.
// Prescaler scenario runs only when PES_GRAYCODE_PRESCALE_EN is defined.
module tb_pes_graycode_updown;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       dir;
    logic       mode;
    logic       load;
    logic [7:0] load_value;
    logic [7:0] gray_count;
    logic [7:0] bin_count;
    logic       tc;

    int n_cmp = 0;
    int n_bad = 0;

    pes_graycode_updown #(.WIDTH(8), .PRESCALE(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .dir        (dir),
        .mode       (mode),
        .load       (load),
        .load_value (load_value),
        .gray_count (gray_count),
        .bin_count  (bin_count),
        .tc         (tc)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0; load = 1'b0; enable = 1'b0;
        dir = 1'b1; mode = 1'b0; load_value = 8'h00;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if (gray_count !== 8'h00 || bin_count !== 8'h00 || tc !== 1'b0) begin
            n_bad++;
            $display("FAIL reset: got g=%h b=%h tc=%b want 00 00 0",
                     gray_count, bin_count, tc);
        end
    endtask

    task automatic test_count_up();
        logic [7:0] exp_g [5] = '{8'h01, 8'h03, 8'h02, 8'h06, 8'h07};
        do_reset();
        enable = 1'b1; dir = 1'b1; mode = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++;
            if (gray_count !== exp_g[i] || bin_count !== 8'(i + 1) || tc !== 1'b0) begin
                n_bad++;
                $display("FAIL count_up[%0d]: got g=%h b=%h tc=%b want %h %h 0",
                         i, gray_count, bin_count, tc, exp_g[i], 8'(i + 1));
            end
        end
    endtask

    task automatic test_down_wrap();
        do_reset();
        enable = 1'b1; dir = 1'b0; mode = 1'b0;
        tick();
        n_cmp++;
        if (gray_count !== 8'h80 || bin_count !== 8'hFF || tc !== 1'b1) begin
            n_bad++;
            $display("FAIL down_wrap: got g=%h b=%h tc=%b want 80 ff 1",
                     gray_count, bin_count, tc);
        end
        tick();
        n_cmp++;
        if (gray_count !== 8'h81 || bin_count !== 8'hFE || tc !== 1'b0) begin
            n_bad++;
            $display("FAIL down_next: got g=%h b=%h tc=%b want 81 fe 0",
                     gray_count, bin_count, tc);
        end
        enable = 1'b0;
        tick();
        n_cmp++;
        if (gray_count !== 8'h81 || bin_count !== 8'hFE || tc !== 1'b0) begin
            n_bad++;
            $display("FAIL hold: got g=%h b=%h tc=%b want 81 fe 0",
                     gray_count, bin_count, tc);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        load = 1'b1; load_value = 8'h80;
        tick();
        n_cmp++;
        if (gray_count !== 8'h80 || bin_count !== 8'hFF || tc !== 1'b0) begin
            n_bad++;
            $display("FAIL sat_load: got g=%h b=%h tc=%b want 80 ff 0",
                     gray_count, bin_count, tc);
        end
        load = 1'b0; dir = 1'b1; mode = 1'b1; enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (gray_count !== 8'h80 || bin_count !== 8'hFF || tc !== 1'b1) begin
                n_bad++;
                $display("FAIL sat_hold[%0d]: got g=%h b=%h tc=%b want 80 ff 1",
                         i, gray_count, bin_count, tc);
            end
        end
        mode = 1'b0;
        tick();
        n_cmp++;
        if (gray_count !== 8'h00 || bin_count !== 8'h00 || tc !== 1'b1) begin
            n_bad++;
            $display("FAIL up_wrap: got g=%h b=%h tc=%b want 00 00 1",
                     gray_count, bin_count, tc);
        end
        tick();
        n_cmp++;
        if (gray_count !== 8'h01 || tc !== 1'b0) begin
            n_bad++;
            $display("FAIL after_wrap: got g=%h tc=%b want 01 0", gray_count, tc);
        end
    endtask

    task automatic test_load_enable();
        do_reset();
        load = 1'b1; enable = 1'b1; dir = 1'b1; load_value = 8'h0C;
        tick();
        n_cmp++;
        if (gray_count !== 8'h0C || bin_count !== 8'h08 || tc !== 1'b0) begin
            n_bad++;
            $display("FAIL load_en: got g=%h b=%h tc=%b want 0c 08 0",
                     gray_count, bin_count, tc);
        end
        load = 1'b0;
        tick();
        n_cmp++;
        if (gray_count !== 8'h0D || bin_count !== 8'h09) begin
            n_bad++;
            $display("FAIL load_step: got g=%h b=%h want 0d 09",
                     gray_count, bin_count);
        end
    endtask

    task automatic test_reset_priority();
        do_reset();
        enable = 1'b1; dir = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        n_cmp++;
        if (gray_count !== 8'h07) begin
            n_bad++;
            $display("FAIL prio_pre: got g=%h want 07", gray_count);
        end
        reset = 1'b0; load = 1'b1; load_value = 8'h55;
        tick();
        n_cmp++;
        if (gray_count !== 8'h00 || bin_count !== 8'h00 || tc !== 1'b0) begin
            n_bad++;
            $display("FAIL prio_reset: got g=%h b=%h tc=%b want 00 00 0",
                     gray_count, bin_count, tc);
        end
        reset = 1'b1; load = 1'b0;
    endtask

    task automatic test_gray_property();
        logic [7:0] prev;
        int         bad;
        do_reset();
        for (int d = 0; d < 2; d++) begin
            dir = d[0]; mode = 1'b0; enable = 1'b1;
            bad = 0;
            prev = gray_count;
            for (int i = 0; i < 258; i++) begin
                tick();
                if ($countones(prev ^ gray_count) != 1 ||
                    gray_count !== (bin_count ^ (bin_count >> 1))) bad++;
                prev = gray_count;
            end
            n_cmp++;
            if (bad != 0) begin
                n_bad++;
                $display("FAIL gray_prop dir=%0d: got %0d bad steps want 0", d, bad);
            end
        end
    endtask

`ifdef PES_GRAYCODE_PRESCALE_EN
    task automatic test_prescale();
        logic [7:0] exp_b;
        do_reset();
        enable = 1'b1; dir = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            exp_b = (k >= 8) ? 8'd2 : (k >= 4) ? 8'd1 : 8'd0;
            n_cmp++;
            if (bin_count !== exp_b || tc !== 1'b0) begin
                n_bad++;
                $display("FAIL prescale[%0d]: got b=%h tc=%b want %h 0",
                         k, bin_count, tc, exp_b);
            end
        end
        n_cmp++;
        if (gray_count !== 8'h03) begin
            n_bad++;
            $display("FAIL prescale_final: got g=%h want 03", gray_count);
        end
        do_reset();
        dir = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            enable = (k == 3 || k == 4) ? 1'b0 : 1'b1;
            tick();
            exp_b = (k >= 6) ? 8'd1 : 8'd0;
            n_cmp++;
            if (bin_count !== exp_b) begin
                n_bad++;
                $display("FAIL prescale_gap[%0d]: got b=%h want %h",
                         k, bin_count, exp_b);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_count_up();
        test_down_wrap();
        test_saturate();
        test_load_enable();
        test_reset_priority();
`ifdef PES_GRAYCODE_PRESCALE_EN
        test_prescale();
`else
        test_gray_property();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
